// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, constants and sigma functions.
//   state_t  : sequencer states IDLE / ROUND / FINAL
//   K        : 64 round constants
//   IV       : initial chaining value H0..H7
//   sigma fns: small (schedule) and big (round) sigma functions
package sha256_pkg;
    localparam int WORD_SIZE = 32;
    localparam int ROUNDS = 64;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
    typedef logic [31:0] word_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
endpackage

// File: rtl/sha256_compression_sequencer_if.sv
// sha256_compression_sequencer_if: host-side bundle of the compression sequencer.
//   start, block_in, hash_in      : host -> sequencer request
//   busy, done, hash_out, round_idx: sequencer -> host status/result
//   master modport for the host, slave modport for the sequencer
interface sha256_compression_sequencer_if;
    import sha256_pkg::*;
    logic                     start;
    logic [16*WORD_SIZE-1:0]  block_in;
    logic [8*WORD_SIZE-1:0]   hash_in;
    logic                     busy;
    logic                     done;
    logic [8*WORD_SIZE-1:0]   hash_out;
    logic [5:0]               round_idx;

    modport master (
        output start, block_in, hash_in,
        input  busy, done, hash_out, round_idx
    );

    modport slave (
        input  start, block_in, hash_in,
        output busy, done, hash_out, round_idx
    );
endinterface

// File: rtl/round_operator.sv
// round_operator: one combinational SHA-256 compression round.
//   a_o..h_o : updated working variables
//   a..h     : current working variables
//   w        : message schedule word W[t]
//   k        : round constant K[t]
module round_operator
    import sha256_pkg::*;
(
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o,
    output word_t e_o,
    output word_t f_o,
    output word_t g_o,
    output word_t h_o,
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    input  word_t e,
    input  word_t f,
    input  word_t g,
    input  word_t h,
    input  word_t w,
    input  word_t k
);
    word_t t1, t2;
    assign t1  = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
    assign t2  = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign a_o = t1 + t2;
    assign b_o = a;
    assign c_o = b;
    assign d_o = c;
    assign e_o = d + t1;
    assign f_o = e;
    assign g_o = f;
    assign h_o = g;
endmodule

// File: rtl/sha256_round_constant_rom.sv
// sha256_round_constant_rom: combinational K[t] lookup.
//   idx : round index t (0..63)
//   k   : round constant K[t]
module sha256_round_constant_rom
    import sha256_pkg::*;
(
    input  logic [5:0] idx,
    output word_t      k
);
    assign k = K[idx];
endmodule

// File: rtl/sha256_compression_sequencer.sv
// sha256_compression_sequencer: runs one 64-round SHA-256 compression per request.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start     : request, sampled only in IDLE
//   bus.block_in  : 512-bit block, W[0] in the top word
//   bus.hash_in   : chaining value H0..H7, H0 in the top word
//   bus.busy      : compression in progress
//   bus.done      : one-cycle pulse when hash_out updates
//   bus.hash_out  : H0'..H7', held until the next completion
//   bus.round_idx : round t being evaluated
module sha256_compression_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int ROUNDS    = 64
) (
    input logic clk,
    input logic rst_n,
    sha256_compression_sequencer_if.slave bus
);
    import sha256_pkg::*;

    state_t state, next_state;
    logic [WORD_SIZE-1:0]   win [16];
    logic [WORD_SIZE-1:0]   wk [8];
    logic [WORD_SIZE-1:0]   chain [8];
    logic [WORD_SIZE-1:0]   nv [8];
    logic [WORD_SIZE-1:0]   k_t;
    logic [WORD_SIZE-1:0]   w_new;
    logic [8*WORD_SIZE-1:0] hash_out;
    logic [5:0]             round_idx;
    logic                   done;
    logic                   accept;

    assign accept        = state == IDLE && bus.start;
    assign bus.busy      = state != IDLE;
    assign bus.done      = done;
    assign bus.hash_out  = hash_out;
    assign bus.round_idx = round_idx;

    // The window always holds W[t..t+15]; word 0 feeds the current round.
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    sha256_round_constant_rom u_rom (
        .idx (round_idx),
        .k   (k_t)
    );

    round_operator u_round (
        .a_o (nv[0]), .b_o (nv[1]), .c_o (nv[2]), .d_o (nv[3]),
        .e_o (nv[4]), .f_o (nv[5]), .g_o (nv[6]), .h_o (nv[7]),
        .a   (wk[0]), .b   (wk[1]), .c   (wk[2]), .d   (wk[3]),
        .e   (wk[4]), .f   (wk[5]), .g   (wk[6]), .h   (wk[7]),
        .w   (win[0]),
        .k   (k_t)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.start ? ROUND : IDLE;
            ROUND:   next_state = round_idx == 6'(ROUNDS - 1) ? FINAL : ROUND;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                wk[i]    <= '0;
                chain[i] <= '0;
            end
            hash_out  <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= state == FINAL;
            if (accept) begin
                for (int i = 0; i < 16; i++) win[i] <= bus.block_in[(15-i)*WORD_SIZE +: WORD_SIZE];
                for (int i = 0; i < 8; i++) begin
                    chain[i] <= bus.hash_in[(7-i)*WORD_SIZE +: WORD_SIZE];
                    wk[i]    <= bus.hash_in[(7-i)*WORD_SIZE +: WORD_SIZE];
                end
                round_idx <= '0;
            end else if (state == ROUND) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
                for (int i = 0; i < 8; i++) wk[i] <= nv[i];
                round_idx <= round_idx + 6'd1;
            end else if (state == FINAL) begin
                for (int i = 0; i < 8; i++) hash_out[(7-i)*WORD_SIZE +: WORD_SIZE] <= chain[i] + wk[i];
            end
        end
    end
endmodule

// File: tb/tb_sha256_compression_sequencer.sv
// tb_sha256_compression_sequencer: self-checking bench for the compression sequencer.
//   Known-answer digests plus random blocks checked against an in-bench SHA-256 model.
module tb_sha256_compression_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sha256_compression_sequencer_if bus();

    sha256_compression_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV_H  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMP_B = {32'h80000000, 480'h0};
    localparam logic [255:0] EMP_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight-line FIPS 180-4 compression: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hv);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Present a request at a negedge; after the accepting edge scramble the inputs.
    task automatic start_block(input logic [511:0] blk, input logic [255:0] hv);
        bus.start    = 1'b1;
        bus.block_in = blk;
        bus.hash_in  = hv;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.block_in = rnd512();
        bus.hash_in  = rnd256();
    endtask

    // Returns edges from the accepting edge to the edge that raised done.
    task automatic wait_done(output int edges);
        int n = 1;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        edges = n - 1;
    endtask

    task automatic check_digest(input string name, input logic [255:0] exp, input int edges);
        vectors++;
        if (bus.hash_out !== exp) begin
            miscompares++;
            $display("FAIL %s digest: got %h want %h", name, bus.hash_out, exp);
        end
        vectors++;
        if (edges !== 65) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want 65", name, edges);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hash_out !== 256'h0 || bus.round_idx !== 6'd0) begin
            miscompares++;
            $display("FAIL %s outputs: busy=%b done=%b round_idx=%0d hash_out=%h want all 0",
                     name, bus.busy, bus.done, bus.round_idx, bus.hash_out);
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.hash_in  = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        int e;
        start_block(ABC_B, IV_H);
        wait_done(e);
        check_digest("abc", ABC_D, e);
        vectors++;
        if (ref_compress(ABC_B, IV_H) !== ABC_D) begin
            miscompares++;
            $display("FAIL abc_model: model digest disagrees with %h", ABC_D);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_pulse: done=%b busy=%b one cycle later, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_empty();
        int e;
        start_block(EMP_B, IV_H);
        wait_done(e);
        check_digest("empty", EMP_D, e);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [447:0] msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        logic [511:0] b1 = {msg, 32'h80000000, 32'h0};
        logic [511:0] b2 = {448'h0, 32'h0, 32'h000001c0};
        int e;
        start_block(b1, IV_H);
        wait_done(e);
        check_digest("two_block_1", ref_compress(b1, IV_H), e);
        start_block(b2, bus.hash_out);
        wait_done(e);
        check_digest("two_block_2", TWO_D, e);
        @(negedge clk);
    endtask

    task automatic test_round_idx();
        int e;
        start_block(ABC_B, IV_H);
        for (int k = 1; k <= 64; k++) begin
            vectors++;
            if (bus.round_idx !== 6'(k - 1) || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL round_idx cycle %0d: round_idx=%0d busy=%b want %0d 1", k, bus.round_idx, bus.busy, k - 1);
            end
            @(negedge clk);
        end
        e = 65;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL final_cycle: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(e);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_cycle: busy=%b done=%b want 0 1", bus.busy, bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int n = 1;
        int extra = 0;
        bit busy_low = 0;
        start_block(ABC_B, IV_H);
        while (!bus.done && n < 200) begin
            if (!bus.busy) busy_low = 1;
            bus.start = (n == 6 || n == 41);
            if (bus.start) begin
                bus.block_in = rnd512();
                bus.hash_in  = rnd256();
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check_digest("busy_start", ABC_D, n - 1);
        vectors++;
        if (busy_low) begin
            miscompares++;
            $display("FAIL busy_start_busy: busy dropped during run, want held high");
        end
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL busy_start_done_count: extra done pulses=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int seen = 0;
        start_block(ABC_B, IV_H);
        for (int n = 1; n < 31; n++) @(negedge clk);
        vectors++;
        if (bus.round_idx !== 6'd30) begin
            miscompares++;
            $display("FAIL reset_mid_round: round_idx=%0d want 30", bus.round_idx);
        end
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: done/busy seen %0d cycles after abort, want 0", seen);
        end
        start_block(ABC_B, IV_H);
        wait_done(e);
        check_digest("reset_mid_rerun", ABC_D, e);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [511:0] b;
        logic [255:0] h;
        int e;
        for (int i = 0; i < 8; i++) begin
            b = rnd512();
            h = rnd256();
            start_block(b, h);
            wait_done(e);
            check_digest($sformatf("random_%0d", i), ref_compress(b, h), e);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_back_to_back();
        test_round_idx();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
